// File: rtl/maf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maf_pkg
// Description : Shared MAF datapath width and resolver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package maf_pkg;

    localparam int MAF_DP_WIDTH = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : maf_pkg
`default_nettype wire

// File: rtl/csa_carry_resolver_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_carry_resolver_if
// Description : Operand and result handshake bundle for the carry resolver.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_carry_resolver_if
    import maf_pkg::*;
#(
    parameter int WIDTH = MAF_DP_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_carry;
    logic [WIDTH-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_zero;

    modport master (
        output in_valid, in_carry, in_sum, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_zero
    );

    modport slave (
        input  in_valid, in_carry, in_sum, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_zero
    );
endinterface : csa_carry_resolver_if
`default_nettype wire

// File: rtl/csa_carry_resolver_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : csa_slice_adder
// Description : Combinational SLICE-bit adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_slice_adder #(
    parameter int SLICE = 12
) (
    input  wire logic [SLICE-1:0] a_i,
    input  wire logic [SLICE-1:0] b_i,
    input  wire logic             c_i,
    output logic      [SLICE-1:0] sum_o,
    output logic                  c_o
);
    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};
endmodule : csa_slice_adder
`default_nettype wire

// File: rtl/csa_carry_resolver.sv
`default_nettype none
// ============================================================================
// Module      : csa_carry_resolver
// Description : Iteratively resolves a carry-save pair into binary, SLICE bits
//               per cycle, behind valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_carry_resolver
    import maf_pkg::*;
#(
    parameter int WIDTH = MAF_DP_WIDTH,
    parameter int SLICE = 12
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    csa_carry_resolver_if.slave bus
);
    localparam int STEPS = WIDTH / SLICE;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    if ((WIDTH % SLICE) != 0) begin : g_slice_check
        $error("csa_carry_resolver: WIDTH must be a multiple of SLICE");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic               cout_q, cout_d, zero_q, zero_d;

    logic               w_accept;
    logic [SLICE-1:0]   w_slice_sum;
    logic               w_slice_cout;
    int                 w_base;

    assign w_base = int'(idx_q) * SLICE;

    // One adder shared by all slices; idx_q selects which slice it sees.
    csa_slice_adder #(.SLICE(SLICE)) u_slice_adder (
        .a_i   (a_q[w_base +: SLICE]),
        .b_i   (b_q[w_base +: SLICE]),
        .c_i   (c_q),
        .sum_o (w_slice_sum),
        .c_o   (w_slice_cout)
    );

    assign bus.in_ready   = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign w_accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_cout   = cout_q;
    assign bus.out_zero   = zero_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (w_accept) state_d = ADD;
            end
            ADD: begin
                res_d[w_base +: SLICE] = w_slice_sum;
                c_d   = w_slice_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // res_d now holds every slice of this operation.
                    cout_d  = w_slice_cout;
                    zero_d  = (res_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = w_accept ? ADD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (w_accept) begin
            a_d   = bus.in_carry;
            b_d   = bus.in_sum;
            idx_d = '0;
            c_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end
endmodule : csa_carry_resolver
`default_nettype wire

// File: tb/tb_csa_carry_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_carry_resolver
// Description : Scoreboard bench: arithmetic reference model, directed corner
//               cases, back-pressure, back-to-back, mid-operation reset, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_carry_resolver;
    localparam int W       = 48;
    localparam int LATENCY = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   seen_valid = 1'b0;
    bit   acc_in_done = 1'b0;
    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;
    logic rnd_bit = 1'b1;

    csa_carry_resolver_if #(.WIDTH(W)) bus ();

    csa_carry_resolver #(.WIDTH(W), .SLICE(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    assign bus.out_ready = rand_ready ? rnd_bit : ready_force;

    function automatic exp_t model(input logic [W-1:0] c, input logic [W-1:0] s);
        exp_t e;
        logic [W:0] total;
        total   = {1'b0, c} + {1'b0, s};
        e.res   = total[W-1:0];
        e.cout  = total[W];
        e.zero  = (total[W-1:0] == '0);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: records accepts into the scoreboard and checks every valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen_valid = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.in_carry, bus.in_sum);
                e.acc_cyc = cyc + 1;
                acc_in_done = bus.out_valid;
                sb.push_back(e);
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(LATENCY));
                    end
                    chk("result", 64'(bus.out_result), 64'(sb[0].res));
                    chk("cout", 64'(bus.out_cout), 64'(sb[0].cout));
                    chk("zero", 64'(bus.out_zero), 64'(sb[0].zero));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        seen_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] c, input logic [W-1:0] s, input bit keep);
        bit ok = 1'b0;
        bus.in_carry = c;
        bus.in_sum   = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_word(output logic [W-1:0] v);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        v = r[W-1:0];
    endtask

    initial begin
        logic [W-1:0] rc, rs;
        bit ok;
        bus.in_valid = 1'b0;
        bus.in_carry = '0;
        bus.in_sum   = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
        chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic corners.
        send(48'h0, 48'h000000000123, 0);            drain();
        send(48'hFFFFFFFFFFFF, 48'h000000000001, 0); drain();
        send(48'h000000000002, 48'h000000000FFE, 0); drain();
        send(48'h000000000002, 48'h000FFFFFFFFE, 0); drain();
        send(48'h000000000001, 48'h0, 0);            drain();

        // Back-pressure in DONE.
        ready_force = 1'b0;
        send(48'h123456789ABC, 48'h0FEDCBA98765, 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", 64'(ok), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 ready_force = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        drain();

        // Back-to-back: second pair must be taken on the first handshake edge.
        send(48'h111111111111, 48'h222222222222, 1);
        send(48'hFFFFFFFFF000, 48'h000000001000, 0);
        chk("b2b_accept_in_done", 64'(acc_in_done), 64'd1);
        drain();

        // Reset during the second ADD cycle.
        send(48'hABCDEF012345, 48'h543210FEDCBA, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_result", 64'(bus.out_result), 64'd0);
        chk("midrst_out_cout", 64'(bus.out_cout), 64'd0);
        chk("midrst_out_zero", 64'(bus.out_zero), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        send(48'h000000000FFF, 48'h000000000001, 0);
        drain();

        // Randomised traffic with random back-pressure and gaps.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rand_word(rs);
            case ($urandom_range(0, 3))
                0: rand_word(rc);
                1: rc = ~rs;
                2: rc = -rs;
                default: rc = 48'hFFFFFFFFFFFF;
            endcase
            send(rc, rs, ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
        drain();
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule : tb_csa_carry_resolver
`default_nettype wire
